// File: rtl/asu_pkg.sv
// Shared constants for the ASU scheduler: datapath width, mode codes and FSM encodings.
package asu_pkg;
    localparam int ASU_W = 8;

    localparam logic ASU_ADD = 1'b0;
    localparam logic ASU_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/asu_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time gets the grant.
module asu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       en,
    output logic       grant,
    output logic [1:0] ready
);
    always_comb begin
        // Requester 1 wins when it is the only one asking, or when both ask and 0 won last.
        grant    = valid[1] & (~valid[0] | ~rr_last);
        ready[0] = en & valid[0] & ~grant;
        ready[1] = en & valid[1] & grant;
    end
endmodule

// File: rtl/asu_sched.sv
// Round-robin scheduler that shares one external asu_gate between two requesters.
// Define ASU_CHECK_EN to add the sticky asu_err output backed by an internal ASU model.
module asu_sched
    import asu_pkg::*;
#(
    parameter int WIDTH = ASU_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic             req1_mode,
    output logic [WIDTH-1:0] asu_x,
    output logic [WIDTH-1:0] asu_y,
    output logic             asu_mode,
    input  logic [WIDTH-1:0] asu_out,
    input  logic             asu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_data,
    output logic [CNT_W-1:0] ops_done
`ifdef ASU_CHECK_EN
    ,
    output logic             asu_err
`endif
);
    state_t state, state_nxt;

    logic                  rr_last;
    logic                  id;
    logic                  grant;
    logic                  accept;
    logic [1:0]            valid;
    logic [1:0]            ready;
    logic [1:0][WIDTH-1:0] op_x;
    logic [1:0][WIDTH-1:0] op_y;
    logic [1:0]            op_mode;

    assign valid   = {req1_valid, req0_valid};
    assign op_x    = {req1_x, req0_x};
    assign op_y    = {req1_y, req0_y};
    assign op_mode = {req1_mode, req0_mode};

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign accept     = |ready;

    // Gating with rst keeps both readys low for the whole reset pulse.
    asu_rr_arb2 u_arb (
        .valid   (valid),
        .rr_last (rr_last),
        .en      ((state == S_IDLE) && !rst),
        .grant   (grant),
        .ready   (ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last   <= 1'b1;
            id        <= 1'b0;
            asu_x     <= '0;
            asu_y     <= '0;
            asu_mode  <= ASU_ADD;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            ops_done  <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                asu_x    <= op_x[grant];
                asu_y    <= op_y[grant];
                asu_mode <= op_mode[grant];
                id       <= grant;
                rr_last  <= grant;
            end
            // The ASU had the whole EXEC cycle to settle on the registered operands.
            if (state == S_EXEC) begin
                rsp_data  <= {asu_carry, asu_out};
                rsp_id    <= id;
                rsp_valid <= 1'b1;
            end
            if (state == S_DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
                ops_done  <= ops_done + CNT_W'(1);
            end
        end
    end

`ifdef ASU_CHECK_EN
    function automatic logic [WIDTH:0] asu_model(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             mode);
        if (mode == ASU_SUB)
            asu_model = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        else
            asu_model = {1'b0, x} + {1'b0, y};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            asu_err <= 1'b0;
        else if (state == S_EXEC && {asu_carry, asu_out} != asu_model(asu_x, asu_y, asu_mode))
            asu_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_asu_sched.sv
// Self-checking bench for asu_sched: drives an ideal ASU and scores responses against arithmetic expectations.
module tb_asu_sched;
    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_mode = 1'b0, req1_mode = 1'b0;
    logic [W-1:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  asu_x, asu_y, asu_out;
    logic          asu_mode, asu_carry;
    logic          rsp_valid, rsp_id;
    logic          rsp_ready = 1'b0;
    logic [W:0]    rsp_data;
    logic [CW-1:0] ops_done;
    logic          fault = 1'b0;
`ifdef ASU_CHECK_EN
    logic          asu_err;
`endif

    int nchk = 0;
    int nerr = 0;
    int exp_ops = 0;
    bit exp_last = 1'b1;

    always #5 clk = ~clk;

    // Stand-in for the external asu_gate; 'fault' zeroes its sum output.
    always_comb begin
        {asu_carry, asu_out} = asu_mode ? ({1'b0, asu_x} + {1'b0, ~asu_y} + 9'd1)
                                        : ({1'b0, asu_x} + {1'b0, asu_y});
        if (fault) asu_out = '0;
    end

    asu_sched #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_mode(req1_mode),
        .asu_x(asu_x), .asu_y(asu_y), .asu_mode(asu_mode), .asu_out(asu_out), .asu_carry(asu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .ops_done(ops_done)
`ifdef ASU_CHECK_EN
        , .asu_err(asu_err)
`endif
    );

    // Expected {carry,result}: subtract carry means "no borrow", i.e. x >= y.
    function automatic logic [8:0] ref_result(input logic [7:0] x, input logic [7:0] y, input logic m);
        int s;
        if (m) begin
            s = int'(x) - int'(y);
            ref_result = {(x >= y), s[7:0]};
        end else begin
            s = int'(x) + int'(y);
            ref_result = s[8:0];
        end
    endfunction

    task automatic set_req(input bit r, input logic v, input logic [7:0] x, input logic [7:0] y, input logic m);
        if (r) begin req1_valid = v; req1_x = x; req1_y = y; req1_mode = m; end
        else   begin req0_valid = v; req0_x = x; req0_y = y; req0_mode = m; end
    endtask

    // One complete transaction for requester r with rsp_ready held high.
    task automatic issue(input bit r, input logic [7:0] x, input logic [7:0] y, input logic m, input string nm);
        int t;
        logic [8:0] e;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(r, 1'b1, x, y, m);
        #1;
        t = 0;
        while (!(r ? req1_ready : req0_ready) && t < 20) begin @(negedge clk); #1; t++; end
        nchk++;
        if (t >= 20) begin nerr++; $display("FAIL %s_grant: req%0d ready stayed 0", nm, r); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_last = r;
        e = ref_result(x, y, m);
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        nchk++;
        if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_id !== r) begin
            nerr++;
            $display("FAIL %s_rsp: valid=%0b id=%0d data=%h, required valid=1 id=%0d data=%h",
                     nm, rsp_valid, rsp_id, rsp_data, r, e);
        end
        @(posedge clk); #1;
        exp_ops = (exp_ops + 1) % 256;
        nchk++;
        if (ops_done !== CW'(exp_ops) || rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL %s_count: ops_done=%0d valid=%0b, required %0d/0", nm, ops_done, rsp_valid, exp_ops);
        end
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #12;
        nchk++;
        if ({rsp_valid, rsp_id, rsp_data} !== 11'd0) begin nerr++; $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_id, rsp_data}); end
        nchk++;
        if (ops_done !== '0) begin nerr++; $display("FAIL reset_ops: got %0d required 0", ops_done); end
        nchk++;
        if ({asu_x, asu_y, asu_mode} !== 17'd0) begin nerr++; $display("FAIL reset_asu: got %h required 0", {asu_x, asu_y, asu_mode}); end
        nchk++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %0b%0b required 00", req1_ready, req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        exp_ops = 0; exp_last = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'h35, 8'h1A, 1'b0);
        #1;
        nchk++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin nerr++; $display("FAIL single_ready: got %0b%0b required 01", req1_ready, req0_ready); end
        @(posedge clk); #1;
        nchk++;
        if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || asu_x !== 8'h35 || asu_y !== 8'h1A || asu_mode !== 1'b0) begin
            nerr++;
            $display("FAIL single_exec: valid=%0b ready=%0b x=%h y=%h m=%0b, required 0 0 35 1a 0", rsp_valid, req0_ready, asu_x, asu_y, asu_mode);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        nchk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 9'h04F) begin
            nerr++;
            $display("FAIL single_rsp: valid=%0b id=%0d data=%h, required 1 0 04f", rsp_valid, rsp_id, rsp_data);
        end
        @(posedge clk); #1;
        exp_ops = 1; exp_last = 1'b0;
        nchk++;
        if (rsp_valid !== 1'b0 || ops_done !== CW'(1)) begin nerr++; $display("FAIL single_done: valid=%0b ops=%0d, required 0 1", rsp_valid, ops_done); end
    endtask

    task automatic test_contention();
        int last_cyc;
        int n_acc;
        bit nxt;
        bit g;
        logic [9:0] q[$];
        logic [9:0] top;
        last_cyc = -1; n_acc = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'h10, 8'h01, 1'b0);
        set_req(1, 1'b1, 8'h20, 8'h01, 1'b1);
        nxt = ~exp_last;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            if (rsp_valid) begin
                nchk++;
                if (q.size() == 0) begin nerr++; $display("FAIL cont_rsp: unexpected response id=%0d", rsp_id); end
                else begin
                    top = q.pop_front();
                    if ({rsp_id, rsp_data} !== top) begin nerr++; $display("FAIL cont_rsp: got %h required %h", {rsp_id, rsp_data}, top); end
                end
                exp_ops = (exp_ops + 1) % 256;
            end
            if (req0_ready || req1_ready) begin
                g = req1_ready;
                nchk++;
                if ((req0_ready && req1_ready) || g !== nxt || (last_cyc >= 0 && i - last_cyc != 3)) begin
                    nerr++;
                    $display("FAIL cont_grant: grant=%0d gap=%0d, required grant=%0d gap=3", g, i - last_cyc, nxt);
                end
                q.push_back({g, g ? 9'h11F : 9'h011});
                last_cyc = i; exp_last = g; nxt = ~g; n_acc++;
            end
            @(negedge clk);
        end
        nchk++;
        if (n_acc != 4 || q.size() != 0 || ops_done !== CW'(exp_ops)) begin
            nerr++;
            $display("FAIL cont_total: accepts=%0d left=%0d ops=%0d, required 4 0 %0d", n_acc, q.size(), ops_done, exp_ops);
        end
    endtask

    task automatic test_backpressure();
        bit g;
        int t;
        logic [8:0] e;
        logic [8:0] e2;
        g = ~exp_last;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'h55, 8'h44, 1'b0);
        set_req(1, 1'b1, 8'h80, 8'h90, 1'b1);
        #1;
        nchk++;
        if ((g ? req1_ready : req0_ready) !== 1'b1) begin nerr++; $display("FAIL bp_grant: ready=%0b%0b, required req%0d", req1_ready, req0_ready, g); end
        @(posedge clk); #1;
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
        exp_last = g;
        e  = g ? ref_result(8'h80, 8'h90, 1'b1) : ref_result(8'h55, 8'h44, 1'b0);
        e2 = g ? ref_result(8'h55, 8'h44, 1'b0) : ref_result(8'h80, 8'h90, 1'b1);
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            nchk++;
            if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_id !== g || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                nerr++;
                $display("FAIL bp_hold: valid=%0b id=%0d data=%h rdy=%0b%0b, required 1 %0d %h 00",
                         rsp_valid, rsp_id, rsp_data, req1_ready, req0_ready, g, e);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        nchk++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin nerr++; $display("FAIL bp_release: rdy=%0b%0b required 00", req1_ready, req0_ready); end
        @(posedge clk); #1;
        exp_ops = (exp_ops + 1) % 256;
        nchk++;
        if (rsp_valid !== 1'b0 || ops_done !== CW'(exp_ops) || (g ? req0_ready : req1_ready) !== 1'b1) begin
            nerr++;
            $display("FAIL bp_next: valid=%0b ops=%0d rdy=%0b%0b, required 0 %0d req%0d", rsp_valid, ops_done, req1_ready, req0_ready, exp_ops, ~g);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_last = ~g;
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        nchk++;
        if (rsp_valid !== 1'b1 || rsp_data !== e2 || rsp_id !== ~g) begin
            nerr++;
            $display("FAIL bp_second: valid=%0b id=%0d data=%h, required 1 %0d %h", rsp_valid, rsp_id, rsp_data, ~g, e2);
        end
        @(posedge clk); #1;
        exp_ops = (exp_ops + 1) % 256;
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        logic [9:0] top;
        bit g;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk);
            if (i < 300) begin
                set_req(0, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
                set_req(1, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
                rsp_ready = $urandom_range(0, 3) != 0;
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
            end
            #1;
            nchk++;
            if (ops_done !== CW'(exp_ops)) begin nerr++; $display("FAIL rnd_ops: got %0d required %0d", ops_done, exp_ops); end
            if (rsp_valid && rsp_ready) begin
                nchk++;
                if (q.size() == 0) begin nerr++; $display("FAIL rnd_rsp: unexpected response"); end
                else begin
                    top = q.pop_front();
                    if ({rsp_id, rsp_data} !== top) begin nerr++; $display("FAIL rnd_rsp: got %h required %h", {rsp_id, rsp_data}, top); end
                end
                exp_ops = (exp_ops + 1) % 256;
            end
            if (req0_ready || req1_ready) begin
                g = req1_ready;
                nchk++;
                if ((req0_ready && req1_ready) || rsp_valid || (g ? !req1_valid : !req0_valid) ||
                    (req0_valid && req1_valid && g == exp_last)) begin
                    nerr++;
                    $display("FAIL rnd_grant: rdy=%0b%0b vld=%0b%0b last=%0d busy=%0b",
                             req1_ready, req0_ready, req1_valid, req0_valid, exp_last, rsp_valid);
                end
                q.push_back(g ? {1'b1, ref_result(req1_x, req1_y, req1_mode)} : {1'b0, ref_result(req0_x, req0_y, req0_mode)});
                exp_last = g;
            end
        end
        nchk++;
        if (q.size() != 0) begin nerr++; $display("FAIL rnd_drain: %0d responses missing, required 0", q.size()); end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (exp_ops != 255 && guard < 300) begin
            issue(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "wrap_fill");
            guard++;
        end
        issue(1'b0, 8'hFF, 8'h01, 1'b0, "wrap");
        nchk++;
        if (ops_done !== '0 || rsp_data !== 9'h100) begin nerr++; $display("FAIL wrap_zero: ops=%0d data=%h, required 0 100", ops_done, rsp_data); end
    endtask

    task automatic test_midreset();
        int t;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 8'hA5, 8'h5A, 1'b1);
        #1;
        t = 0;
        while (!req1_ready && t < 20) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        nchk++;
        if (asu_x !== 8'hA5 || asu_y !== 8'h5A) begin nerr++; $display("FAIL mr_latch: x=%h y=%h, required a5 5a", asu_x, asu_y); end
        rst = 1'b1;
        #1;
        nchk++;
        if (rsp_valid !== 1'b0 || ops_done !== '0 || asu_x !== '0 || asu_y !== '0 || asu_mode !== 1'b0 || rsp_data !== '0) begin
            nerr++;
            $display("FAIL mr_clear: valid=%0b ops=%0d x=%h y=%h m=%0b data=%h, required all 0", rsp_valid, ops_done, asu_x, asu_y, asu_mode, rsp_data);
        end
        @(posedge clk); #1;
        nchk++;
        if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL mr_discard: valid=%0b required 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0; exp_last = 1'b1;
        set_req(0, 1'b1, 8'h0C, 8'h0D, 1'b1);
        set_req(1, 1'b1, 8'h11, 8'h22, 1'b0);
        #1;
        nchk++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin nerr++; $display("FAIL mr_first: rdy=%0b%0b required 01", req1_ready, req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_last = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        nchk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== ref_result(8'h0C, 8'h0D, 1'b1)) begin
            nerr++;
            $display("FAIL mr_rsp: valid=%0b id=%0d data=%h, required 1 0 %h", rsp_valid, rsp_id, rsp_data, ref_result(8'h0C, 8'h0D, 1'b1));
        end
        @(posedge clk); #1;
        exp_ops = 1;
    endtask

`ifdef ASU_CHECK_EN
    task automatic test_checker();
        int t;
        nchk++;
        if (asu_err !== 1'b0) begin nerr++; $display("FAIL chk_clean: asu_err=%0b required 0", asu_err); end
        @(negedge clk);
        rsp_ready = 1'b1;
        fault = 1'b1;
        set_req(0, 1'b1, 8'h03, 8'h04, 1'b0);
        #1;
        t = 0;
        while (!req0_ready && t < 20) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        nchk++;
        if (asu_err !== 1'b1 || rsp_data !== 9'h000) begin nerr++; $display("FAIL chk_detect: asu_err=%0b data=%h, required 1 000", asu_err, rsp_data); end
        fault = 1'b0;
        @(posedge clk); #1;
        exp_ops = (exp_ops + 1) % 256; exp_last = 1'b0;
        issue(1'b1, 8'h40, 8'h02, 1'b1, "chk_ok1");
        issue(1'b0, 8'h07, 8'h08, 1'b0, "chk_ok2");
        nchk++;
        if (asu_err !== 1'b1) begin nerr++; $display("FAIL chk_sticky: asu_err=%0b required 1", asu_err); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nchk++;
        if (asu_err !== 1'b0) begin nerr++; $display("FAIL chk_reset: asu_err=%0b required 0", asu_err); end
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0; exp_last = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_random();
        test_wrap();
        test_midreset();
`ifdef ASU_CHECK_EN
        test_checker();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/asu_sched.md
Name: asu_sched

Overview:
- Round-robin scheduler that shares one combinational asu_gate (8-bit add/subtract unit) between two requesters.
- Latches the granted operands and drives the ASU's x/y/mode from registers.
- Captures {carry,out} one cycle later and returns it on a response channel, tagged with the requester ID and stalled by backpressure.
- Sits between the operand sources and the single ASU instance; the ASU stays outside this block.

Parameters:
- WIDTH, 8, operand width; must match the ASU datapath.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_x  input  WIDTH  requester 0 operand x
- req0_y  input  WIDTH  requester 0 operand y
- req0_mode  input  1  0 = add, 1 = subtract
- req1_valid / req1_ready / req1_x / req1_y / req1_mode: same widths and meaning for requester 1
- asu_x  output  WIDTH  to ASU x
- asu_y  output  WIDTH  to ASU y
- asu_mode  output  1  to ASU mode
- asu_out  input  WIDTH  from ASU out
- asu_carry  input  1  from ASU carry
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_id  output  1  requester that issued the result
- rsp_data  output  WIDTH+1  {carry,out}
- ops_done  output  CNT_W  completed responses

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_last=1 (so requester 0 wins first), asu_x/asu_y/asu_mode=0, rsp_valid=0, rsp_id=0, rsp_data=0, ops_done=0. Both readys are 0 while rst=1.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
- IDLE arbitration:
  - grant = the valid requester not equal to rr_last when both are valid; otherwise the sole valid requester.
  - reqN_ready = (state==IDLE) && grant==N; this is combinational from the valids.
  - Readys are 0 in EXEC and DONE.
- Accept (edge where valid&&ready):
  - latch x, y, mode into asu_x, asu_y, asu_mode;
  - latch id; set rr_last=id; go to EXEC.
- EXEC: one full cycle for ASU settle. At the next edge: rsp_data <= {asu_carry,asu_out}, rsp_id <= id, rsp_valid <= 1, state -> DONE.
- DONE: rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1. On that edge: rsp_valid <= 0, ops_done++, state -> IDLE.
- asu_x/asu_y/asu_mode hold their last values outside EXEC; they do not return to 0.
- Latency: accept at edge k, rsp_valid high after edge k+1. Minimum issue interval is 3 cycles (rsp_ready tied 1).
- A requester that drops valid before ready is simply not granted. Operands are sampled only on the accept edge.
- No valid in IDLE: stay in IDLE, no counter change.
- ops_done wraps from 2^CNT_W-1 to 0.
- rst asserted mid-operation: in-flight op discarded, no response, all outputs return to reset values immediately.
- Subtract semantics are the ASU's own: rsp_data is passed through unmodified.

Optional Feature:
- ASU_CHECK_EN defined adds output port asu_err (1 bit) plus an internal model of the ASU.
  - Model: add = x+y (WIDTH+1 bits); subtract = x + ~y + 1 (WIDTH+1 bits, carry = bit WIDTH).
  - At the EXEC capture edge, {asu_carry,asu_out} != model sets asu_err.
  - asu_err is sticky until rst; its reset value is 0.
- ASU_CHECK_EN not defined: no asu_err port, no model logic, behaviour otherwise identical.

Decomposition:
- Shared package asu_pkg:
  - ASU_W=8;
  - mode constants ASU_ADD=1'b0, ASU_SUB=1'b1;
  - FSM state encodings S_IDLE=2'd0, S_EXEC=2'd1, S_DONE=2'd2.
- One sub-module asu_rr_arb2: inputs valid[1:0], rr_last, en; output grant id and per-requester ready.
- Everything else lives in asu_sched.

Test Plan:
- Single op: req0 x=8'h35, y=8'h1A, mode 0, rsp_ready=1 -> req0_ready at accept, rsp_valid 2 edges later, rsp_id=0, rsp_data=9'h04F, ops_done=1.
- Contention: both valid continuously, ops 0x10+0x01 (req0) and 0x20-0x01 (req1) -> grants alternate 0,1,0,1; each response id matches its requester; issues are 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after result -> rsp_valid/rsp_data stay stable; both readys 0; no second accept until the cycle after rsp_ready=1.
- Overflow/wrap: x=8'hFF, y=8'h01 add -> rsp_data=9'h100. Preload ops_done=16'hFFFF by running ops, then one more -> ops_done 0.
- Reset mid-op: assert rst during EXEC -> rsp_valid=0, ops_done=0, asu_x=0 immediately. The next op is granted to req0 first.
- ASU_CHECK_EN: force asu_out to 8'h00 for one add 0x03+0x04 -> asu_err=1 and it stays 1 across later correct ops until rst.
